pipelined_controller: RTL and testbench
=======================================

PIPELINED_CONTROLLER -- requirements
Module: pipelined_controller

Interface
REQ-001 SHALL have parameter ALUCTRL_W, default 4 (minimum 4), width of the ALU control code; upper bits above bit 3 are zero.
REQ-002 SHALL have parameter CNT_W, default 32, width of each performance counter.
REQ-003 SHALL have port clk, input, 1, sole clock, with all state updating on the rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports opD, funct3D and funct7b5D, inputs of 7, 3 and 1 bits, the Decode instruction fields.
REQ-006 SHALL have ports ZeroE, LtE and LtuE, inputs, 1 each: ALU equal, signed-less-than and unsigned-less-than flags.
REQ-007 SHALL have ports stallE, stallM, flushE and flushM, inputs, 1 each, the per-stage hold and clear requests from the hazard unit.
REQ-008 SHALL have port ImmSrcD, output, 3, immediate format: I=000, S=001, B=010, J=011, U=100.
REQ-009 SHALL have port IllegalD, output, 1, asserted when opD is unsupported.
REQ-010 SHALL have port ALUControlE, output, ALUCTRL_W; port ALUSrcE, output, 1; port JumpE, output, 1; port JalrE, output, 1; port PCSrcE, output, 1.
REQ-011 SHALL have ports ResultSrcE, ResultSrcM and ResultSrcW, outputs, 2 each: 00=ALU, 01=memory, 10=PC+4, 11=immediate.
REQ-012 SHALL have ports MemWriteM, RegWriteM and RegWriteW, outputs, 1 each; port Funct3M, output, 3, load/store size.

Function
REQ-013 SHALL decode lw, sw, R-type, I-ALU, all six branch types, jal, jalr, lui and auipc combinationally in Decode.
REQ-014 SHALL encode ALU codes as ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8 and SRA 9; SUB and SRA are selected by funct7b5D, with SUB applying only when opD[5]=1.
REQ-015 SHALL decode an illegal opcode as a bubble, with all write enables, Branch, Jump and the valid bit at 0.
REQ-016 SHALL hold the control fields and a valid bit in three registers, D->E, E->M and M->W, giving 1 cycle of latency per stage.
REQ-017 SHALL compute the branch condition in Execute from funct3E: 000 uses ZeroE, 001 uses !ZeroE, 100 uses LtE, 101 uses !LtE, 110 uses LtuE, 111 uses !LtuE, and 010/011 never take the branch.
REQ-018 SHALL drive PCSrcE = validE & !stallE & ((BranchE & cond) | JumpE), so the redirect is issued exactly once per instruction.
REQ-019 SHALL assert JalrE only for jalr in Execute, selecting the ALU result as the branch target.
REQ-020 SHALL handle stallE by holding the D->E register and loading a bubble into E->M.
REQ-021 SHALL handle stallM by holding both D->E and E->M and loading a bubble into M->W, which implies stallE.
REQ-022 SHALL give flushX priority over stallX in the same stage, clearing that register to a bubble.
REQ-023 SHALL make every bubble clear RegWrite, MemWrite, Branch, Jump and valid, and set ResultSrc to 00.

Reset
REQ-024 SHALL, on reset low, immediately clear every pipeline register to a bubble, independent of clk, including during a stall or flush.
REQ-025 SHALL hold every registered output at 0 after reset: RegWriteM, RegWriteW, MemWriteM, PCSrcE, JumpE, JalrE, all ResultSrc and ALUControlE.
REQ-026 SHALL resume normal capture on the first rising edge after reset is released.

Configuration
REQ-027 SHALL, with CTRL_PERF_EN defined, add outputs RetireCnt and TakenCnt of CNT_W bits each.
REQ-028 SHALL increment RetireCnt on each cycle validW=1 and TakenCnt on each cycle PCSrcE=1, with both counters wrapping modulo 2^CNT_W and resetting to 0.
REQ-029 SHALL, without CTRL_PERF_EN, omit these ports and their logic entirely.

Verification
REQ-030 SHALL cover a back-to-back program add, lw, sw, where ResultSrcW is 00, 01 and then a bubble, RegWriteW is 1, 1, 0, and MemWriteM pulses exactly once for sw.
REQ-031 SHALL cover bne with ZeroE=0 -> PCSrcE=1 and bge with LtE=1 -> PCSrcE=0, plus all six branch funct3 codes.
REQ-032 SHALL cover jalr held 3 cycles by stallE -> PCSrcE=1 only in the release cycle, JalrE=1, ResultSrcE=10.
REQ-033 SHALL cover flushE and stallE asserted together with beq valid in Decode -> next cycle JumpE=0, RegWriteM=0 after one further cycle.
REQ-034 SHALL cover opD=7'b0000000 -> IllegalD=1, no write enables reach M or W, and RetireCnt unchanged.
REQ-035 SHALL cover reset asserted mid-stream between clock edges -> RegWriteM, MemWriteM and PCSrcE at 0 immediately, and with CTRL_PERF_EN with CNT_W=4, RetireCnt wraps from 15 to 0 after 16 retirements.

Source files
------------

// File: rtl/pipelined_controller.sv
// pipelined_controller
// Control path of a five-stage RV32I pipeline. Decode is combinational; the
// control word then travels through D->E, E->M and M->W registers, each of
// which can be held, flushed or loaded with a bubble by the hazard unit.
// Optional feature macro: CTRL_PERF_EN adds the RetireCnt/TakenCnt
// performance counters. Without it, those ports and their logic are absent.
module pipelined_controller #(
  parameter int ALUCTRL_W = 4,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opD,
  input  logic [2:0]           funct3D,
  input  logic                 funct7b5D,
  input  logic                 ZeroE,
  input  logic                 LtE,
  input  logic                 LtuE,
  input  logic                 stallE,
  input  logic                 stallM,
  input  logic                 flushE,
  input  logic                 flushM,
  output logic [2:0]           ImmSrcD,
  output logic                 IllegalD,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 ALUSrcE,
  output logic                 JumpE,
  output logic                 JalrE,
  output logic                 PCSrcE,
  output logic [1:0]           ResultSrcE,
  output logic [1:0]           ResultSrcM,
  output logic [1:0]           ResultSrcW,
  output logic                 MemWriteM,
  output logic                 RegWriteM,
  output logic                 RegWriteW,
  output logic [2:0]           Funct3M
`ifdef CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]     RetireCnt,
  output logic [CNT_W-1:0]     TakenCnt
`endif
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  // An all-zero word of any of these structs is a bubble.
  typedef struct packed {
    logic                 valid;
    logic                 regWrite;
    logic [1:0]           resultSrc;
    logic                 memWrite;
    logic                 branch;
    logic                 jump;
    logic                 jalr;
    logic                 aluSrc;
    logic [ALUCTRL_W-1:0] aluControl;
    logic [2:0]           funct3;
  } ctrlET;

  typedef struct packed {
    logic       valid;
    logic       regWrite;
    logic [1:0] resultSrc;
    logic       memWrite;
    logic [2:0] funct3;
  } ctrlMT;

  typedef struct packed {
    logic       valid;
    logic       regWrite;
    logic [1:0] resultSrc;
  } ctrlWT;

  ctrlET ctrlD;
  ctrlET ctrlE;
  ctrlMT ctrlM;
  ctrlMT ctrlEtoM;
  ctrlWT ctrlW;
  ctrlWT ctrlMtoW;
  logic  [3:0] aluCode;
  logic  stallAnyE;
  logic  branchCond;

  // ALU operation for R-type and I-ALU; SUB only exists for register operands.
  function automatic logic [3:0] aluDecode(input logic [2:0] f3, input logic f7b5,
                                           input logic opBit5);
    logic [3:0] code;
    case (f3)
      3'b000:  code = (f7b5 & opBit5) ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      3'b111:  code = ALU_AND;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

  // Branch condition from the ALU flags; 010/011 are not branch encodings.
  function automatic logic branchTaken(input logic [2:0] f3, input logic z,
                                       input logic lt, input logic ltu);
    logic taken;
    case (f3)
      3'b000:  taken = z;
      3'b001:  taken = ~z;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // Decode: build the control word; unknown opcodes become a bubble.
  always_comb begin
    ctrlD    = '0;
    ImmSrcD  = IMM_I;
    IllegalD = 1'b0;
    aluCode  = ALU_ADD;
    case (opD)
      OP_LOAD: begin
        ctrlD.valid = 1'b1; ctrlD.regWrite = 1'b1; ctrlD.resultSrc = RES_MEM;
        ctrlD.aluSrc = 1'b1; ImmSrcD = IMM_I;
      end
      OP_STORE: begin
        ctrlD.valid = 1'b1; ctrlD.memWrite = 1'b1; ctrlD.aluSrc = 1'b1;
        ImmSrcD = IMM_S;
      end
      OP_RTYPE: begin
        ctrlD.valid = 1'b1; ctrlD.regWrite = 1'b1; ctrlD.resultSrc = RES_ALU;
        aluCode = aluDecode(funct3D, funct7b5D, opD[5]);
      end
      OP_IALU: begin
        ctrlD.valid = 1'b1; ctrlD.regWrite = 1'b1; ctrlD.resultSrc = RES_ALU;
        ctrlD.aluSrc = 1'b1; ImmSrcD = IMM_I;
        aluCode = aluDecode(funct3D, funct7b5D, opD[5]);
      end
      OP_BRANCH: begin
        ctrlD.valid = 1'b1; ctrlD.branch = 1'b1; ImmSrcD = IMM_B;
        aluCode = ALU_SUB;
      end
      OP_JAL: begin
        ctrlD.valid = 1'b1; ctrlD.regWrite = 1'b1; ctrlD.resultSrc = RES_PC4;
        ctrlD.jump = 1'b1; ImmSrcD = IMM_J;
      end
      OP_JALR: begin
        ctrlD.valid = 1'b1; ctrlD.regWrite = 1'b1; ctrlD.resultSrc = RES_PC4;
        ctrlD.jump = 1'b1; ctrlD.jalr = 1'b1; ctrlD.aluSrc = 1'b1; ImmSrcD = IMM_I;
      end
      OP_LUI: begin
        ctrlD.valid = 1'b1; ctrlD.regWrite = 1'b1; ctrlD.resultSrc = RES_IMM;
        ImmSrcD = IMM_U;
      end
      OP_AUIPC: begin
        ctrlD.valid = 1'b1; ctrlD.regWrite = 1'b1; ctrlD.resultSrc = RES_ALU;
        ctrlD.aluSrc = 1'b1; ImmSrcD = IMM_U;
      end
      default: IllegalD = 1'b1;
    endcase
    if (IllegalD) begin
      ctrlD.funct3 = 3'b000;
    end else begin
      ctrlD.funct3 = funct3D;
      ctrlD.aluControl[3:0] = aluCode;
    end
  end

  // A memory-stage stall also freezes Execute.
  assign stallAnyE = stallE | stallM;

  // Field forwarding between stages.
  always_comb begin
    ctrlEtoM.valid     = ctrlE.valid;
    ctrlEtoM.regWrite  = ctrlE.regWrite;
    ctrlEtoM.resultSrc = ctrlE.resultSrc;
    ctrlEtoM.memWrite  = ctrlE.memWrite;
    ctrlEtoM.funct3    = ctrlE.funct3;
    ctrlMtoW.valid     = ctrlM.valid;
    ctrlMtoW.regWrite  = ctrlM.regWrite;
    ctrlMtoW.resultSrc = ctrlM.resultSrc;
  end

  // D->E register: flush beats stall; a held register keeps its instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrlE <= '0;
    end else if (flushE) begin
      ctrlE <= '0;
    end else if (stallAnyE) begin
      ctrlE <= ctrlE;
    end else begin
      ctrlE <= ctrlD;
    end
  end

  // E->M register: a stalled Execute stage sends a bubble downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrlM <= '0;
    end else if (flushM) begin
      ctrlM <= '0;
    end else if (stallM) begin
      ctrlM <= ctrlM;
    end else if (stallE) begin
      ctrlM <= '0;
    end else begin
      ctrlM <= ctrlEtoM;
    end
  end

  // M->W register: a stalled Memory stage sends a bubble to Writeback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrlW <= '0;
    end else if (stallM) begin
      ctrlW <= '0;
    end else begin
      ctrlW <= ctrlMtoW;
    end
  end

  // Redirect only when the instruction actually leaves Execute, so it fires once.
  assign branchCond = branchTaken(ctrlE.funct3, ZeroE, LtE, LtuE);
  assign PCSrcE     = ctrlE.valid & ~stallAnyE & ((ctrlE.branch & branchCond) | ctrlE.jump);

  assign ALUControlE = ctrlE.aluControl;
  assign ALUSrcE     = ctrlE.aluSrc;
  assign JumpE       = ctrlE.jump;
  assign JalrE       = ctrlE.jalr;
  assign ResultSrcE  = ctrlE.resultSrc;
  assign ResultSrcM  = ctrlM.resultSrc;
  assign ResultSrcW  = ctrlW.resultSrc;
  assign Funct3M     = ctrlM.funct3;
  // Write enables are qualified by valid so a corrupted bubble cannot write.
  assign MemWriteM   = ctrlM.memWrite & ctrlM.valid;
  assign RegWriteM   = ctrlM.regWrite & ctrlM.valid;
  assign RegWriteW   = ctrlW.regWrite & ctrlW.valid;

`ifdef CTRL_PERF_EN
  // Retirement counter: one count per valid instruction reaching Writeback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RetireCnt <= '0;
    end else if (ctrlW.valid) begin
      RetireCnt <= RetireCnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      RetireCnt <= RetireCnt;
    end
  end

  // Redirect counter: one count per cycle a PC redirect is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      TakenCnt <= '0;
    end else if (PCSrcE) begin
      TakenCnt <= TakenCnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      TakenCnt <= TakenCnt;
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_controller.sv
// Directed self-checking bench for pipelined_controller.
// Define CTRL_PERF_EN to also exercise the performance counters (CNT_W=4).
module tb_pipelined_controller;
  localparam int ALUCTRL_W = 4;
  localparam int CNT_W     = 4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BAD    = 7'b0000000;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] opD;
  logic [2:0] funct3D;
  logic funct7b5D, ZeroE, LtE, LtuE, stallE, stallM, flushE, flushM;
  logic [2:0] ImmSrcD;
  logic IllegalD;
  logic [ALUCTRL_W-1:0] ALUControlE;
  logic ALUSrcE, JumpE, JalrE, PCSrcE;
  logic [1:0] ResultSrcE, ResultSrcM, ResultSrcW;
  logic MemWriteM, RegWriteM, RegWriteW;
  logic [2:0] Funct3M;
`ifdef CTRL_PERF_EN
  logic [CNT_W-1:0] RetireCnt, TakenCnt;
`endif

  int checks = 0;
  int errors = 0;

  pipelined_controller #(.ALUCTRL_W(ALUCTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
    .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE), .stallE(stallE), .stallM(stallM),
    .flushE(flushE), .flushM(flushM), .ImmSrcD(ImmSrcD), .IllegalD(IllegalD),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .JumpE(JumpE), .JalrE(JalrE),
    .PCSrcE(PCSrcE), .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM),
    .ResultSrcW(ResultSrcW), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .Funct3M(Funct3M)
`ifdef CTRL_PERF_EN
    , .RetireCnt(RetireCnt), .TakenCnt(TakenCnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [2:0] imm;
    logic [1:0] res;
    logic [3:0] alu;
    logic       chkAlu;
  } decVecT;

  decVecT decVecs [18] = '{
    '{OP_RTYPE,  3'b000, 1'b0, 3'b000, 2'b00, 4'd0, 1'b1},  // add
    '{OP_RTYPE,  3'b000, 1'b1, 3'b000, 2'b00, 4'd1, 1'b1},  // sub
    '{OP_IALU,   3'b000, 1'b1, 3'b000, 2'b00, 4'd0, 1'b1},  // addi, bit5 set
    '{OP_IALU,   3'b101, 1'b1, 3'b000, 2'b00, 4'd9, 1'b1},  // srai
    '{OP_RTYPE,  3'b101, 1'b0, 3'b000, 2'b00, 4'd8, 1'b1},  // srl
    '{OP_IALU,   3'b011, 1'b0, 3'b000, 2'b00, 4'd6, 1'b1},  // sltiu
    '{OP_RTYPE,  3'b010, 1'b0, 3'b000, 2'b00, 4'd5, 1'b1},  // slt
    '{OP_RTYPE,  3'b111, 1'b0, 3'b000, 2'b00, 4'd2, 1'b1},  // and
    '{OP_IALU,   3'b110, 1'b0, 3'b000, 2'b00, 4'd3, 1'b1},  // ori
    '{OP_RTYPE,  3'b100, 1'b0, 3'b000, 2'b00, 4'd4, 1'b1},  // xor
    '{OP_IALU,   3'b001, 1'b0, 3'b000, 2'b00, 4'd7, 1'b1},  // slli
    '{OP_LOAD,   3'b010, 1'b0, 3'b000, 2'b01, 4'd0, 1'b1},  // lw
    '{OP_STORE,  3'b010, 1'b0, 3'b001, 2'b00, 4'd0, 1'b1},  // sw
    '{OP_BRANCH, 3'b000, 1'b0, 3'b010, 2'b00, 4'd0, 1'b0},  // beq
    '{OP_JAL,    3'b000, 1'b0, 3'b011, 2'b10, 4'd0, 1'b0},  // jal
    '{OP_JALR,   3'b000, 1'b0, 3'b000, 2'b10, 4'd0, 1'b1},  // jalr
    '{OP_LUI,    3'b000, 1'b0, 3'b100, 2'b11, 4'd0, 1'b0},  // lui
    '{OP_AUIPC,  3'b000, 1'b0, 3'b100, 2'b00, 4'd0, 1'b0}   // auipc
  };

  // Branch funct3 and expected PCSrcE for flag patterns
  // A: Z=1 Lt=0 Ltu=0   B: Z=0 Lt=1 Ltu=1   C: Z=0 Lt=1 Ltu=0
  logic [2:0] brF3 [7] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010};
  logic       brExpA [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       brExpB [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       brExpC [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic setD(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opD = op;
    funct3D = f3;
    funct7b5D = f7;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setFlags(input logic z, input logic lt, input logic ltu);
    ZeroE = z;
    LtE = lt;
    LtuE = ltu;
  endtask

  initial begin
    logic [2:0] prevF3;
    reset = 1'b0;
    setD(OP_BAD, 3'b000, 1'b0);
    setFlags(1'b0, 1'b0, 1'b0);
    stallE = 1'b0; stallM = 1'b0; flushE = 1'b0; flushM = 1'b0;
    #1;
    checkVal("rst_RegWriteM", RegWriteM, 0);
    checkVal("rst_RegWriteW", RegWriteW, 0);
    checkVal("rst_MemWriteM", MemWriteM, 0);
    checkVal("rst_PCSrcE", PCSrcE, 0);
    checkVal("rst_ALUControlE", ALUControlE, 0);
    checkVal("rst_ResultSrcW", ResultSrcW, 0);
    tick();
    reset = 1'b1;
    tick();

    // Decode table
    prevF3 = 3'b000;
    for (int i = 0; i < 18; i++) begin
      setD(decVecs[i].op, decVecs[i].f3, decVecs[i].f7);
      #1;
      checkVal($sformatf("dec%0d_ImmSrcD", i), ImmSrcD, decVecs[i].imm);
      checkVal($sformatf("dec%0d_IllegalD", i), IllegalD, 0);
      tick();
      checkVal($sformatf("dec%0d_ResultSrcE", i), ResultSrcE, decVecs[i].res);
      checkVal($sformatf("dec%0d_Funct3M", i), Funct3M, prevF3);
      if (decVecs[i].chkAlu) begin
        checkVal($sformatf("dec%0d_ALUControlE", i), ALUControlE, decVecs[i].alu);
      end else begin
        checkVal($sformatf("dec%0d_JumpE", i), JumpE, (decVecs[i].op == OP_JAL) ? 1 : 0);
      end
      prevF3 = decVecs[i].f3;
    end
    setD(OP_BAD, 3'b000, 1'b0);
    repeat (3) tick();

    // add, lw, sw back to back
    setD(OP_RTYPE, 3'b000, 1'b0);
    tick();
    checkVal("prog_add_ALUSrcE", ALUSrcE, 0);
    setD(OP_LOAD, 3'b010, 1'b0);
    tick();
    checkVal("prog_lw_ALUSrcE", ALUSrcE, 1);
    checkVal("prog_add_RegWriteM", RegWriteM, 1);
    setD(OP_STORE, 3'b010, 1'b0);
    tick();
    checkVal("prog_add_ResultSrcW", ResultSrcW, 0);
    checkVal("prog_add_RegWriteW", RegWriteW, 1);
    checkVal("prog_lw_MemWriteM", MemWriteM, 0);
    setD(OP_BAD, 3'b000, 1'b0);
    tick();
    checkVal("prog_lw_ResultSrcW", ResultSrcW, 1);
    checkVal("prog_lw_RegWriteW", RegWriteW, 1);
    checkVal("prog_sw_MemWriteM", MemWriteM, 1);
    tick();
    checkVal("prog_sw_ResultSrcW", ResultSrcW, 0);
    checkVal("prog_sw_RegWriteW", RegWriteW, 0);
    checkVal("prog_after_MemWriteM", MemWriteM, 0);
    repeat (2) tick();

    // Branch conditions for every funct3
    for (int i = 0; i < 7; i++) begin
      setD(OP_BRANCH, brF3[i], 1'b0);
      tick();
      setD(OP_BAD, 3'b000, 1'b0);
      setFlags(1'b1, 1'b0, 1'b0);
      #1 checkVal($sformatf("br%0d_A_PCSrcE", brF3[i]), PCSrcE, brExpA[i]);
      setFlags(1'b0, 1'b1, 1'b1);
      #1 checkVal($sformatf("br%0d_B_PCSrcE", brF3[i]), PCSrcE, brExpB[i]);
      setFlags(1'b0, 1'b1, 1'b0);
      #1 checkVal($sformatf("br%0d_C_PCSrcE", brF3[i]), PCSrcE, brExpC[i]);
      setFlags(1'b0, 1'b0, 1'b0);
    end
    tick();

    // jalr held three cycles by stallE
    setD(OP_JALR, 3'b000, 1'b0);
    tick();
    setD(OP_BAD, 3'b000, 1'b0);
    stallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkVal($sformatf("jalr_stall%0d_PCSrcE", i), PCSrcE, 0);
      checkVal($sformatf("jalr_stall%0d_JalrE", i), JalrE, 1);
      tick();
    end
    checkVal("jalr_stall_RegWriteM", RegWriteM, 0);
    stallE = 1'b0;
    #1;
    checkVal("jalr_rel_PCSrcE", PCSrcE, 1);
    checkVal("jalr_rel_JalrE", JalrE, 1);
    checkVal("jalr_rel_ResultSrcE", ResultSrcE, 2);
    tick();
    checkVal("jalr_after_PCSrcE", PCSrcE, 0);
    checkVal("jalr_after_RegWriteM", RegWriteM, 1);

    // flushE and stallE together with beq in Decode
    setD(OP_RTYPE, 3'b000, 1'b0);
    tick();
    setD(OP_BRANCH, 3'b000, 1'b0);
    flushE = 1'b1; stallE = 1'b1;
    tick();
    flushE = 1'b0; stallE = 1'b0;
    setD(OP_BAD, 3'b000, 1'b0);
    ZeroE = 1'b1;
    #1;
    checkVal("fs_JumpE", JumpE, 0);
    checkVal("fs_PCSrcE", PCSrcE, 0);
    checkVal("fs_RegWriteM0", RegWriteM, 0);
    tick();
    checkVal("fs_RegWriteM1", RegWriteM, 0);
    ZeroE = 1'b0;
    repeat (2) tick();

    // stallM holds E and M, bubbles W
    setD(OP_LOAD, 3'b010, 1'b0);
    tick();
    setD(OP_BAD, 3'b000, 1'b0);
    stallM = 1'b1;
    tick();
    stallM = 1'b0;
    #1;
    checkVal("sm_ResultSrcE", ResultSrcE, 1);
    checkVal("sm_RegWriteM", RegWriteM, 0);
    tick();
    checkVal("sm_rel_RegWriteM", RegWriteM, 1);
    checkVal("sm_rel_ResultSrcM", ResultSrcM, 1);
    tick();
    checkVal("sm_rel_RegWriteW", RegWriteW, 1);
    repeat (3) tick();

    // Reset asserted between clock edges
    setD(OP_STORE, 3'b010, 1'b0);
    tick();
    setD(OP_JAL, 3'b000, 1'b0);
    tick();
    setD(OP_BAD, 3'b000, 1'b0);
    #1;
    checkVal("pre_rst_MemWriteM", MemWriteM, 1);
    checkVal("pre_rst_PCSrcE", PCSrcE, 1);
    #2 reset = 1'b0;
    #1;
    checkVal("mid_rst_MemWriteM", MemWriteM, 0);
    checkVal("mid_rst_PCSrcE", PCSrcE, 0);
    checkVal("mid_rst_RegWriteM", RegWriteM, 0);
    checkVal("mid_rst_ResultSrcE", ResultSrcE, 0);
    tick();
    reset = 1'b1;
    setD(OP_RTYPE, 3'b000, 1'b0);
    tick();
    setD(OP_BAD, 3'b000, 1'b0);
    tick();
    checkVal("post_rst_RegWriteM", RegWriteM, 1);

    // 14 more adds: 15 retirements since reset
    for (int i = 0; i < 14; i++) begin
      setD(OP_RTYPE, 3'b000, 1'b0);
      tick();
    end
    setD(OP_BAD, 3'b000, 1'b0);
    repeat (5) tick();
`ifdef CTRL_PERF_EN
    checkVal("perf_RetireCnt15", RetireCnt, 15);
    checkVal("perf_TakenCnt0", TakenCnt, 0);
`endif

    // Illegal opcode: bubble, nothing written, nothing retired
    setD(OP_BAD, 3'b000, 1'b0);
    #1;
    checkVal("ill_IllegalD", IllegalD, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkVal($sformatf("ill%0d_RegWriteM", i), RegWriteM, 0);
      checkVal($sformatf("ill%0d_RegWriteW", i), RegWriteW, 0);
      checkVal($sformatf("ill%0d_MemWriteM", i), MemWriteM, 0);
    end
`ifdef CTRL_PERF_EN
    checkVal("ill_RetireCnt", RetireCnt, 15);
`endif

    // 16th retirement wraps the counter; a jal bumps TakenCnt
    setD(OP_RTYPE, 3'b000, 1'b0);
    tick();
    setD(OP_BAD, 3'b000, 1'b0);
    repeat (5) tick();
`ifdef CTRL_PERF_EN
    checkVal("perf_RetireWrap", RetireCnt, 0);
`endif
    setD(OP_JAL, 3'b000, 1'b0);
    tick();
    setD(OP_BAD, 3'b000, 1'b0);
    #1 checkVal("perf_jal_PCSrcE", PCSrcE, 1);
    repeat (5) tick();
`ifdef CTRL_PERF_EN
    checkVal("perf_TakenCnt1", TakenCnt, 1);
    checkVal("perf_RetireCnt1", RetireCnt, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
